axis_channel_join: RTL and testbench

// - Consumes the CHANNELS independent per-channel AXI-Stream outputs of the channel buffer stage and merges them into one wide stream.
// - A beat leaves only when every channel has contributed exactly one beat, so channels that drift apart in time are realigned before the wide consumer.
// - One holding slot per channel plus one registered output stage. Full throughput when all channels and the sink keep up.

---
 rtl/axis_channel_join.sv | 133 +++++++++++++
 tb/tb_axis_channel_join.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_channel_join.sv
// Joins CHANNELS independent AXI-Stream inputs into one wide beat once every channel has a beat.
// Optional tlast consistency checking is enabled by defining CHANNEL_JOIN_LAST_CHECK_EN.
module axis_channel_join #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
  parameter bit          LAST_ENABLE = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           last_err,
  input  logic                           last_err_clr
);

  localparam int unsigned DW = CHANNELS * DATA_WIDTH;
  localparam int unsigned KW = CHANNELS * KEEP_WIDTH;

  logic [CHANNELS-1:0] slot_full_q, slot_full_d;
  logic [CHANNELS-1:0] slot_last_q, slot_last_d;
  logic [DW-1:0]       slot_data_q, slot_data_d;
  logic [KW-1:0]       slot_keep_q, slot_keep_d;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [KW-1:0] out_keep_q, out_keep_d;
  logic          out_last_q, out_last_d;
  logic          last_err_q, last_err_d;

  logic                all_full, out_free, load;
  logic [CHANNELS-1:0] s_fire;
  logic                last_join;

  assign all_full      = &slot_full_q;
  assign out_free      = ~out_valid_q | m_axis_tready;
  assign load          = all_full & out_free;
  // Ready looks through a pending load so a full slot can be refilled on the releasing edge.
  assign s_axis_tready = ~slot_full_q | {CHANNELS{load}};
  assign s_fire        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    slot_full_d = slot_full_q;
    slot_last_d = slot_last_q;
    slot_data_d = slot_data_q;
    slot_keep_d = slot_keep_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s_fire[c]) begin
        slot_full_d[c]                          = 1'b1;
        slot_last_d[c]                          = s_axis_tlast[c];
        slot_data_d[c*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        slot_keep_d[c*KEEP_WIDTH +: KEEP_WIDTH] = s_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
      end else if (load) begin
        slot_full_d[c] = 1'b0;
      end
    end
  end

`ifdef CHANNEL_JOIN_LAST_CHECK_EN
  assign last_join = |slot_last_q;

  always_comb begin
    last_err_d = last_err_q;
    if (last_err_clr) begin
      last_err_d = 1'b0;
    end
    if (load && !((&slot_last_q) || !(|slot_last_q))) begin
      last_err_d = 1'b1;
    end
  end
`else
  logic [CHANNELS:0] unused_last;

  assign last_join   = slot_last_q[0];
  assign unused_last = {last_err_clr, slot_last_q};
  assign last_err_d  = 1'b0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = slot_data_q;
      out_keep_d  = slot_keep_q;
      out_last_d  = LAST_ENABLE ? last_join : 1'b0;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_full_q <= '0;
      slot_last_q <= '0;
      slot_data_q <= '0;
      slot_keep_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      last_err_q  <= 1'b0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_last_q <= slot_last_d;
      slot_data_q <= slot_data_d;
      slot_keep_q <= slot_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      last_err_q  <= last_err_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = KEEP_ENABLE ? out_keep_q : '1;
  assign m_axis_tlast  = out_last_q;
  assign last_err      = last_err_q;

endmodule

// File: tb/tb_axis_channel_join.sv
// Scoreboard bench for axis_channel_join: per-channel source queues feed the DUT, a negedge
// monitor pops expected joined beats and compares.
module tb_axis_channel_join;

  localparam int C  = 4;
  localparam int DW = 16;
  localparam int KW = 2;
`ifdef CHANNEL_JOIN_LAST_CHECK_EN
  localparam bit LastChk = 1'b1;
`else
  localparam bit LastChk = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } src_t;

  typedef struct packed {
    logic [C*DW-1:0] d;
    logic [C*KW-1:0] k;
    logic            l;
    logic            e;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [C*DW-1:0] s_data = '0;
  logic [C*KW-1:0] s_keep = '0;
  logic [C-1:0]    s_valid = '0;
  logic [C-1:0]    s_ready;
  logic [C-1:0]    s_last = '0;
  logic [C*DW-1:0] m_data;
  logic [C*KW-1:0] m_keep;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            m_last;
  logic            err;
  logic            err_clr = 1'b0;

  axis_channel_join #(
    .CHANNELS  (C),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_data),
    .s_axis_tkeep (s_keep),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tlast (s_last),
    .m_axis_tdata (m_data),
    .m_axis_tkeep (m_keep),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast (m_last),
    .last_err     (err),
    .last_err_clr (err_clr)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   p0 = 0;
  int   first_out = -1;
  int   last_out = -1;
  int   n_out = 0;
  int   start_c[C];
  src_t src_q[C][$];
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [C*DW-1:0] row(input int n);
    logic [C*DW-1:0] r;
    for (int c = 0; c < C; c++) r[c*DW +: DW] = 16'(c * 256 + n);
    return r;
  endfunction

  task automatic push_row(input logic [C*DW-1:0] d, input logic [C*KW-1:0] k,
                          input logic [C-1:0] l, input logic [C*DW-1:0] ed,
                          input logic [C*KW-1:0] ek, input logic el, input logic ee);
    src_t s;
    exp_t e;
    for (int c = 0; c < C; c++) begin
      s.d = d[c*DW +: DW];
      s.k = k[c*KW +: KW];
      s.l = l[c];
      src_q[c].push_back(s);
    end
    e.d = ed;
    e.k = ek;
    e.l = el;
    e.e = ee;
    exp_q.push_back(e);
  endtask

  task automatic push_std(input int n);
    logic [15:0] b;
    b = 16'(n);
    push_row(row(n), 8'hFF, 4'b0000,
             {16'h0300 + b, 16'h0200 + b, 16'h0100 + b, b}, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic drive();
    for (int c = 0; c < C; c++) begin
      if (src_q[c].size() > 0 && cyc >= start_c[c]) begin
        s_valid[c]          = 1'b1;
        s_data[c*DW +: DW]  = src_q[c][0].d;
        s_keep[c*KW +: KW]  = src_q[c][0].k;
        s_last[c]           = src_q[c][0].l;
      end else begin
        s_valid[c]          = 1'b0;
        s_data[c*DW +: DW]  = '0;
        s_keep[c*KW +: KW]  = '0;
        s_last[c]           = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [C-1:0] acc;
    src_t         t;
    @(negedge clk);
    acc = s_valid & s_ready;
    @(posedge clk);
    for (int c = 0; c < C; c++) begin
      if (acc[c]) t = src_q[c].pop_front();
    end
    cyc++;
    #1;
    drive();
  endtask

  task automatic begin_scn();
    first_out = -1;
    last_out  = -1;
    n_out     = 0;
    p0        = cyc;
    for (int c = 0; c < C; c++) start_c[c] = cyc;
  endtask

  // Monitor: pops on every handshake, and checks the held beat while stalled.
  always @(negedge clk) begin
    if (rst && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", {63'b0, m_valid}, 64'd0);
      end else if (m_ready) begin
        mon_e = exp_q.pop_front();
        chk("beat_data", m_data, mon_e.d);
        chk("beat_keep", {56'b0, m_keep}, {56'b0, mon_e.k});
        chk("beat_last", {63'b0, m_last}, {63'b0, mon_e.l});
        chk("beat_err", {63'b0, err}, {63'b0, mon_e.e});
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end else begin
        chk("hold_data", m_data, exp_q[0].d);
      end
    end
  end

  initial begin
    src_t t;
    for (int c = 0; c < C; c++) start_c[c] = 0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'b0, m_valid}, 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_keep", {56'b0, m_keep}, 64'd0);
    chk("rst_last", {63'b0, m_last}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_ready", {60'b0, s_ready}, 64'hF);
    rst = 1'b1;

    // Aligned streaming
    begin_scn();
    m_ready = 1'b1;
    for (int n = 0; n < 8; n++) push_std(n);
    drive();
    repeat (12) tick();
    chk("aligned_latency", 64'(first_out), 64'(p0 + 2));
    chk("aligned_rate", 64'(last_out), 64'(p0 + 9));
    chk("aligned_count", 64'(n_out), 64'd8);

    // Channel 2 starts 5 cycles late
    begin_scn();
    start_c[2] = cyc + 5;
    for (int n = 32; n < 36; n++) push_std(n);
    drive();
    repeat (3) tick();
    #1;
    chk("skew_ready", {60'b0, s_ready}, 64'h4);
    repeat (12) tick();
    chk("skew_latency", 64'(first_out), 64'(p0 + 7));
    chk("skew_last_beat", 64'(last_out), 64'(p0 + 10));
    chk("skew_count", 64'(n_out), 64'd4);

    // Backpressure for 10 cycles
    begin_scn();
    for (int n = 64; n < 80; n++) push_std(n);
    drive();
    repeat (3) tick();
    m_ready = 1'b0;
    repeat (10) tick();
    #1;
    chk("bp_ready", {60'b0, s_ready}, 64'h0);
    m_ready = 1'b1;
    repeat (25) tick();
    chk("bp_count", 64'(n_out), 64'd16);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset with output valid and slots 0,1 full
    begin_scn();
    m_ready = 1'b0;
    push_std(96);
    drive();
    repeat (3) tick();
    t.k = 2'b11;
    t.l = 1'b0;
    t.d = 16'h0070;
    src_q[0].push_back(t);
    t.d = 16'h0171;
    src_q[1].push_back(t);
    drive();
    tick();
    #1;
    chk("pre_rst_valid", {63'b0, m_valid}, 64'd1);
    chk("pre_rst_ready", {60'b0, s_ready}, 64'hC);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'b0, m_valid}, 64'd0);
    chk("mid_rst_ready", {60'b0, s_ready}, 64'hF);
    chk("mid_rst_data", m_data, 64'd0);
    for (int c = 0; c < C; c++) src_q[c].delete();
    exp_q.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b1;
    begin_scn();
    push_std(128);
    drive();
    repeat (6) tick();
    chk("post_rst_count", 64'(n_out), 64'd1);
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

    // tlast mismatch: only channel 1 marks last
    begin_scn();
    push_row(row(144), 8'hFF, 4'b0010, 64'h0390_0290_0190_0090, 8'hFF, LastChk, LastChk);
    drive();
    repeat (5) tick();
    #1;
    chk("err_sticky", {63'b0, err}, {63'b0, LastChk});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("err_cleared", {63'b0, err}, 64'd0);
    push_row(row(160), 8'h7F, 4'b1111, 64'h03A0_02A0_01A0_00A0, 8'h7F, 1'b1, 1'b0);
    push_row(row(161), 8'hFF, 4'b0001, 64'h03A1_02A1_01A1_00A1, 8'hFF, 1'b1, LastChk);
    drive();
    repeat (8) tick();
    chk("last_count", 64'(n_out), 64'd3);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
